memory_access: RTL and testbench

Memory-access (MA) pipeline stage between the execute stage and the MA/WB writeback register. It consumes the EX/MEM register outputs and drives the data-cache request/response handshake for loads and stores. It raises `MA_stall` while a data access is outstanding. It aligns load data, selects the writeback value, and registers everything into MA/WB; the registered writeback value is also the MA/WB forwarding source for the execute stage.

---
 rtl/memory_access.sv | 162 ++++++++++++++++
 tb/tb_memory_access.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: drives the data-cache handshake, aligns load data and
// registers the MA/WB results, including the writeback/forwarding value.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic        load_regfile;
  } rv32i_control_word;

endpackage

module memory_access
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic              IF_stall,
  input  logic              data_resp,
  input  logic [31:0]       data_rdata,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_mbe,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out,
  output logic              br_en_out,
  output logic [31:0]       mem_wb_data
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_buf_q;
  logic        is_load, is_store, mem_op, not_hold, advance;
  logic [31:0] load_word, shifted_word, aligned_load, wb_next;

  assign is_load  = (ctrl_word_in.opcode == op_load);
  assign is_store = (ctrl_word_in.opcode == op_store);
  assign mem_op   = is_load | is_store;
  assign not_hold = (state_q != StHold);

  assign data_addr  = {alu_in[31:2], 2'b00};
  assign data_wdata = rs2_in << {alu_in[1:0], 3'b000};
  assign data_mbe   = mem_byte_enable_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWait: begin
        if (data_resp) begin
          state_d = IF_stall ? StHold : StIdle;
        end else if (mem_op) begin
          state_d = StWait;
        end
      end
      StHold: begin
        if (!IF_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; requests drop during reset so an abandoned access is never re-driven
  always_comb begin
    data_read  = is_load & not_hold & ~rst;
    data_write = is_store & not_hold & ~rst;
    MA_stall   = mem_op & not_hold & ~data_resp & ~rst;
  end

  // Response captured while the pipe is frozen, replayed once IF_stall drops
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_buf_q <= '0;
    end else if (not_hold && data_resp && IF_stall) begin
      rdata_buf_q <= data_rdata;
    end
  end

  assign advance      = ~MA_stall & ~IF_stall;
  assign load_word    = data_resp ? data_rdata : rdata_buf_q;
  assign shifted_word = load_word >> {alu_in[1:0], 3'b000};

  always_comb begin
    case (instruction_in[14:12])
      lb:      aligned_load = {{24{shifted_word[7]}}, shifted_word[7:0]};
      lbu:     aligned_load = {24'b0, shifted_word[7:0]};
      lh:      aligned_load = {{16{shifted_word[15]}}, shifted_word[15:0]};
      lhu:     aligned_load = {16'b0, shifted_word[15:0]};
      default: aligned_load = load_word;
    endcase
  end

  always_comb begin
    case (ctrl_word_in.opcode)
      op_load:         wb_next = aligned_load;
      op_jal, op_jalr: wb_next = PC_in + 32'd4;
      default:         wb_next = alu_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_word_out   <= '0;
      instruction_out <= '0;
      PC_out          <= '0;
      alu_out         <= '0;
      br_en_out       <= 1'b0;
      mem_wb_data     <= '0;
    end else if (advance) begin
      ctrl_word_out   <= ctrl_word_in;
      instruction_out <= instruction_in;
      PC_out          <= PC_in;
      alu_out         <= alu_in;
      br_en_out       <= br_en_in;
      mem_wb_data     <= wb_next;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU passthrough, aligned loads, stores, jal wrap,
// response buffered under IF_stall, and reset during an outstanding access.
module tb_memory_access;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  rv32i_control_word ctrl_word_in;
  logic [31:0]       instruction_in, PC_in, alu_in, rs2_in;
  logic              br_en_in;
  logic [3:0]        mem_byte_enable_in;
  logic              IF_stall, data_resp;
  logic [31:0]       data_rdata;
  logic              data_read, data_write, MA_stall, br_en_out;
  logic [31:0]       data_addr, data_wdata, instruction_out, PC_out, alu_out, mem_wb_data;
  logic [3:0]        data_mbe;
  rv32i_control_word ctrl_word_out;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_word_in       (ctrl_word_in),
    .instruction_in     (instruction_in),
    .PC_in              (PC_in),
    .alu_in             (alu_in),
    .rs2_in             (rs2_in),
    .br_en_in           (br_en_in),
    .mem_byte_enable_in (mem_byte_enable_in),
    .IF_stall           (IF_stall),
    .data_resp          (data_resp),
    .data_rdata         (data_rdata),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_mbe           (data_mbe),
    .MA_stall           (MA_stall),
    .ctrl_word_out      (ctrl_word_out),
    .instruction_out    (instruction_out),
    .PC_out             (PC_out),
    .alu_out            (alu_out),
    .br_en_out          (br_en_out),
    .mem_wb_data        (mem_wb_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rv32i_opcode op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [3:0] mbe);
    ctrl_word_in.opcode = op;
    instruction_in      = {17'b0, f3, 12'b0};
    PC_in               = pc;
    alu_in              = addr;
    rs2_in              = rs2;
    mem_byte_enable_in  = mbe;
  endtask

  // Drives one access with 'waits' response-less cycles, then a one-cycle response.
  task automatic mem_txn(input string tag, input rv32i_opcode op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] rs2, input logic [3:0] mbe, input int waits,
                         input logic [31:0] rdata);
    drive(op, f3, 32'h0000_0200, addr, rs2, mbe);
    data_resp = 1'b0;
    #1;
    for (int i = 0; i < waits; i++) begin
      check_eq({tag, "_stall"}, 32'(MA_stall), 32'd1);
      check_eq({tag, "_rd"}, 32'(data_read), 32'(op == op_load));
      check_eq({tag, "_wr"}, 32'(data_write), 32'(op == op_store));
      check_eq({tag, "_addr"}, data_addr, exp_addr);
      tick();
    end
    data_resp  = 1'b1;
    data_rdata = rdata;
    #1;
    check_eq({tag, "_resp_nostall"}, 32'(MA_stall), 32'd0);
    tick();
    data_resp  = 1'b0;
    data_rdata = 32'h0;
  endtask

  initial begin
    rst                 = 1'b1;
    ctrl_word_in        = '0;
    ctrl_word_in.opcode = op_load;
    instruction_in      = '0;
    PC_in               = 32'h55;
    alu_in              = 32'h77;
    rs2_in              = '0;
    br_en_in            = 1'b1;
    mem_byte_enable_in  = 4'hF;
    IF_stall            = 1'b0;
    data_resp           = 1'b0;
    data_rdata          = '0;
    #2;
    check_eq("rst_no_read", 32'(data_read), 32'd0);
    check_eq("rst_no_stall", 32'(MA_stall), 32'd0);
    tick();
    check_eq("rst_wb", mem_wb_data, 32'h0);
    check_eq("rst_pc", PC_out, 32'h0);
    check_eq("rst_br", 32'(br_en_out), 32'd0);
    rst = 1'b0;

    // ALU op: no stall, one edge of latency
    drive(op_imm, 3'b000, 32'h40, 32'h0000_1234, 32'h0, 4'h0);
    #1;
    check_eq("alu_nostall", 32'(MA_stall), 32'd0);
    check_eq("alu_noread", 32'(data_read), 32'd0);
    check_eq("alu_nowrite", 32'(data_write), 32'd0);
    tick();
    check_eq("alu_wb", mem_wb_data, 32'h0000_1234);
    check_eq("alu_pc", PC_out, 32'h40);
    check_eq("alu_br", 32'(br_en_out), 32'd1);

    mem_txn("lb", op_load, 3'b000, 32'h103, 32'h100, 32'h0, 4'hF, 2, 32'h80AA_BBCC);
    check_eq("lb_wb", mem_wb_data, 32'hFFFF_FF80);
    mem_txn("lhu", op_load, 3'b101, 32'h102, 32'h100, 32'h0, 4'hF, 1, 32'h8001_FFFF);
    check_eq("lhu_wb", mem_wb_data, 32'h0000_8001);
    mem_txn("lh", op_load, 3'b001, 32'h102, 32'h100, 32'h0, 4'hF, 1, 32'h8001_FFFF);
    check_eq("lh_wb", mem_wb_data, 32'hFFFF_8001);
    // Zero-wait response: no stall cycle at all
    mem_txn("lw", op_load, 3'b010, 32'h100, 32'h100, 32'h0, 4'hF, 0, 32'h8001_FFFF);
    check_eq("lw_wb", mem_wb_data, 32'h8001_FFFF);

    // Store request held across a wait cycle
    drive(op_store, 3'b000, 32'h300, 32'h101, 32'h0000_00AB, 4'b0010);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("sb_write", 32'(data_write), 32'd1);
      check_eq("sb_noread", 32'(data_read), 32'd0);
      check_eq("sb_wdata", data_wdata, 32'h0000_AB00);
      check_eq("sb_mbe", 32'(data_mbe), 32'h2);
      check_eq("sb_stall", 32'(MA_stall), 32'd1);
      tick();
    end
    data_resp = 1'b1;
    #1;
    check_eq("sb_resp_nostall", 32'(MA_stall), 32'd0);
    tick();
    data_resp = 1'b0;
    check_eq("sb_wb", mem_wb_data, 32'h101);

    drive(op_jal, 3'b000, 32'hFFFF_FFFC, 32'h999, 32'h0, 4'h0);
    tick();
    check_eq("jal_wrap", mem_wb_data, 32'h0);
    drive(op_jalr, 3'b000, 32'h100, 32'h999, 32'h0, 4'h0);
    tick();
    check_eq("jalr_wb", mem_wb_data, 32'h104);

    // Response arrives while IF_stall is high: buffered in HOLD, not reissued
    drive(op_load, 3'b100, 32'h500, 32'h101, 32'h0, 4'hF);
    #1;
    check_eq("hold_pre_stall", 32'(MA_stall), 32'd1);
    tick();
    IF_stall   = 1'b1;
    data_resp  = 1'b1;
    data_rdata = 32'h1234_5678;
    #1;
    check_eq("hold_resp_nostall", 32'(MA_stall), 32'd0);
    tick();
    data_resp  = 1'b0;
    data_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      check_eq("hold_noread", 32'(data_read), 32'd0);
      check_eq("hold_nostall", 32'(MA_stall), 32'd0);
      check_eq("hold_wb_frozen", mem_wb_data, 32'h104);
      check_eq("hold_pc_frozen", PC_out, 32'h100);
      tick();
    end
    IF_stall = 1'b0;
    #1;
    check_eq("hold_release_noread", 32'(data_read), 32'd0);
    tick();
    check_eq("hold_wb", mem_wb_data, 32'h0000_0056);
    check_eq("hold_pc", PC_out, 32'h500);

    // Reset while an access is outstanding
    drive(op_load, 3'b010, 32'h600, 32'h200, 32'h0, 4'hF);
    data_rdata = 32'h0;
    tick();
    check_eq("wait_stall", 32'(MA_stall), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstwait_noread", 32'(data_read), 32'd0);
    check_eq("rstwait_nostall", 32'(MA_stall), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("rstwait_wb", mem_wb_data, 32'h0);
    check_eq("rstwait_op", 32'(ctrl_word_out.opcode), 32'h0);
    check_eq("rstwait_alu", alu_out, 32'h0);
    // Back in IDLE: an ALU op proceeds without stalling
    drive(op_reg, 3'b000, 32'h700, 32'h0000_BEEF, 32'h0, 4'h0);
    #1;
    check_eq("post_rst_nostall", 32'(MA_stall), 32'd0);
    tick();
    check_eq("post_rst_wb", mem_wb_data, 32'h0000_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end by 100000");
    $fatal(1);
  end

endmodule
